// File: rtl/handshake_tx_pkg.sv
// Shared definitions for the clocked 4-phase bundled-data transmitter:
// FSM state encodings and default data width.
package handshake_tx_pkg;

  localparam int DEFAULT_DATA_WIDTH = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_REQ_HI = 2'd2;
  localparam logic [1:0] ST_REQ_LO = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    REQ_HI = ST_REQ_HI,
    REQ_LO = ST_REQ_LO
  } tx_state_e;

endpackage

// File: rtl/handshake_tx_if.sv
// Source-side valid/ready bus plus the bundled-data request/acknowledge pair
// toward the asynchronous pipeline.
interface handshake_tx_if
  import handshake_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  req_out;
  logic                  ack_in;
  logic [DATA_WIDTH-1:0] data_out;

  // master: the environment (source and pipeline); slave: the transmitter
  modport master (
    output in_valid,
    output in_data,
    output ack_in,
    input  in_ready,
    input  req_out,
    input  data_out
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  ack_in,
    output in_ready,
    output req_out,
    output data_out
  );

endinterface

// File: rtl/handshake_tx_fifo.sv
// Pointer-plus-count synchronous FIFO with a combinational head read; a push
// while full is dropped even if a pop happens in the same cycle.
module hs_tx_fifo
  import handshake_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign full      = (r_count == FULL_COUNT);
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/handshake_tx.sv
// Clocked feeder for the asynchronous 4-phase bundled-data pipeline: buffers
// source words and runs a return-to-zero handshake against a synchronized ack.
module handshake_tx
  import handshake_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int DEPTH        = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  handshake_tx_if.slave        bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] tx_count
);

  localparam int SCW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [SCW-1:0] SETUP_LAST = SCW'(SETUP_CYCLES - 1);

  tx_state_e              r_state;
  logic                   r_req;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [SCW-1:0]         r_setup_cnt;
  logic [CNT_WIDTH-1:0]   r_tx_count;
  logic [SYNC_STAGES-1:0] r_ack_sync;

  logic                   w_ack_s;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [DATA_WIDTH-1:0]  w_fifo_dout;

  // ack_in is asynchronous to clk; only the last synchronizer stage is trusted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.ack_in};
    end
  end

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  assign w_push = bus.in_valid && !w_full;
  assign w_pop  = (r_state == IDLE) && !w_empty && !w_ack_s;

  hs_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.in_data),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // data_out is loaded only when leaving IDLE, so it is frozen for the whole
  // request phase and until the pipeline's ack has been seen low again
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req       <= 1'b0;
      r_data      <= '0;
      r_setup_cnt <= '0;
      r_tx_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_data      <= w_fifo_dout;
            r_setup_cnt <= '0;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          if (r_setup_cnt == SETUP_LAST) begin
            r_req   <= 1'b1;
            r_state <= REQ_HI;
          end else begin
            r_setup_cnt <= r_setup_cnt + 1'b1;
          end
        end
        REQ_HI: begin
          if (w_ack_s) begin
            r_req   <= 1'b0;
            r_state <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!w_ack_s) begin
            r_tx_count <= r_tx_count + 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = !w_full;
  assign bus.req_out  = r_req;
  assign bus.data_out = r_data;
  assign busy         = (r_state != IDLE) || !w_empty;
  assign tx_count     = r_tx_count;

endmodule

// File: tb/tb_handshake_tx.sv
// Randomized bench for handshake_tx: a word queue plus a responding pipeline
// model predict transfer order, setup timing, and handshake counts.
module tb_handshake_tx;
  import handshake_tx_pkg::*;

  localparam int DW    = 3;
  localparam int DEPTH = 4;
  localparam int SETUP = 3;
  localparam int SYNC  = 2;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy;
  logic [CW-1:0] txCount;

  logic respEnable = 1'b0;
  logic ackResp    = 1'b0;
  logic ackManual  = 1'b0;

  int checks = 0;
  int errors = 0;
  int completions = 0;

  logic [DW-1:0] expQ [$];
  logic [DW-1:0] expWord;
  logic [DW-1:0] lastWord;
  logic [DW-1:0] prevData;
  logic          prevReq;
  logic          prevAck;
  int            sinceChange;
  int            ackLowAge;
  bit            acc;

  handshake_tx_if #(.DATA_WIDTH(DW)) bus ();

  handshake_tx #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .SETUP_CYCLES (SETUP),
    .SYNC_STAGES  (SYNC),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .tx_count (txCount)
  );

  always #5 clk = ~clk;

  assign bus.ack_in = respEnable ? ackResp : ackManual;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  task automatic waitNeg();
    @(negedge clk);
    #1;
  endtask

  // Offer one word; the source sees in_ready before the edge, so a word
  // offered while ready is taken on that edge
  task automatic applyStimulus(input logic [DW-1:0] word, input int maxWait, output bit accepted);
    accepted = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    for (int i = 0; i < maxWait && !accepted; i++) begin
      if (bus.in_ready) begin
        accepted = 1'b1;
        expQ.push_back(word);
      end
      waitNeg();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      waitNeg();
      n++;
    end
    checkOutput(tag, busy, 1'b0);
  endtask

  task automatic waitReq(input logic level, input int budget, input string tag);
    int n = 0;
    while (bus.req_out !== level && n < budget) begin
      waitNeg();
      n++;
    end
    checkOutput(tag, bus.req_out, level);
  endtask

  // Pipeline model: raises ack some cycles after req, drops it after req falls
  initial begin
    forever begin
      waitNeg();
      if (!respEnable || rst) begin
        ackResp = 1'b0;
      end else if (bus.req_out && !ackResp && $urandom_range(0, 2) == 0) begin
        ackResp = 1'b1;
      end else if (!bus.req_out && ackResp && $urandom_range(0, 2) == 0) begin
        ackResp = 1'b0;
        completions++;
      end
    end
  end

  // Observer: every request carries the next queued word, data only moves
  // while the handshake is fully returned to zero
  always @(negedge clk) begin
    if (rst) begin
      prevReq     = 1'b0;
      prevData    = '0;
      prevAck     = bus.ack_in;
      lastWord    = '0;
      sinceChange = 0;
      ackLowAge   = 100;
    end else begin
      if (!bus.ack_in) begin
        ackLowAge = prevAck ? 1 : ackLowAge + 1;
      end
      if (bus.data_out !== prevData) begin
        checkOutput("dataChangeAllowed",
                    32'(!prevReq && !bus.req_out && !bus.ack_in && ackLowAge > SYNC), 32'd1);
        sinceChange = 0;
      end else begin
        sinceChange++;
      end
      if (prevReq && bus.req_out) begin
        checkOutput("dataStableDuringReq", bus.data_out, prevData);
      end
      if (bus.req_out && !prevReq) begin
        if (expQ.size() == 0) begin
          checkOutput("reqWithoutWord", 32'd1, 32'd0);
        end else begin
          expWord = expQ.pop_front();
          checkOutput("wordOrder", bus.data_out, expWord);
          if (expWord != lastWord) begin
            checkOutput("setupCycles", sinceChange, SETUP);
          end
          lastWord = expWord;
        end
      end
      prevReq  = bus.req_out;
      prevData = bus.data_out;
      prevAck  = bus.ack_in;
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset values and first-word latency
    repeat (3) waitNeg();
    rst = 1'b0;
    waitNeg();
    checkOutput("resetReq", bus.req_out, 0);
    checkOutput("resetData", bus.data_out, 0);
    checkOutput("resetInReady", bus.in_ready, 1);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetTxCount", txCount, 0);

    applyStimulus(3'd1, 1, acc);
    checkOutput("firstAccepted", acc, 1);
    checkOutput("latencyEdgeK", bus.data_out, 0);
    waitNeg();
    checkOutput("latencyDataK1", bus.data_out, 1);
    checkOutput("latencyReqK1", bus.req_out, 0);
    repeat (SETUP - 1) waitNeg();
    checkOutput("latencyReqEarly", bus.req_out, 0);
    waitNeg();
    checkOutput("latencyReqRise", bus.req_out, 1);
    ackManual = 1'b1;
    waitReq(1'b0, 20, "reqFallFirst");
    ackManual = 1'b0;
    completions++;
    waitIdle(50, "idleAfterFirst");
    checkOutput("txCountFirst", txCount, completions % 4);

    // Stale ack blocks popping so the FIFO fills; a fifth word is refused
    ackManual = 1'b1;
    repeat (SYNC + 2) waitNeg();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(DW'(i), 1, acc);
      checkOutput("fillAccepted", acc, 1);
    end
    checkOutput("fullInReady", bus.in_ready, 0);
    applyStimulus(3'd5, 3, acc);
    checkOutput("fifthRefused", acc, 0);
    checkOutput("staleNoPopData", bus.data_out, 1);
    checkOutput("staleNoReq", bus.req_out, 0);
    ackManual  = 1'b0;
    respEnable = 1'b1;
    waitIdle(400, "idleAfterFill");
    checkOutput("fillDrained", expQ.size(), 0);
    checkOutput("txCountFill", txCount, completions % 4);

    // Reset in the middle of REQ_HI with words queued, ack held through release
    respEnable = 1'b0;
    applyStimulus(3'd5, 5, acc);
    applyStimulus(3'd3, 5, acc);
    applyStimulus(3'd7, 5, acc);
    waitReq(1'b1, 30, "reqHiBeforeReset");
    checkOutput("reqHiData", bus.data_out, 5);
    #2 rst = 1'b1;
    ackManual = 1'b1;
    #1;
    checkOutput("asyncResetReq", bus.req_out, 0);
    checkOutput("asyncResetData", bus.data_out, 0);
    checkOutput("asyncResetBusy", busy, 0);
    checkOutput("asyncResetTxCount", txCount, 0);
    checkOutput("asyncResetInReady", bus.in_ready, 1);
    expQ.delete();
    completions = 0;
    repeat (2) waitNeg();
    rst = 1'b0;
    repeat (SYNC + 2) waitNeg();
    applyStimulus(3'd6, 2, acc);
    checkOutput("staleLoadAccepted", acc, 1);
    repeat (6) waitNeg();
    checkOutput("staleHoldReq", bus.req_out, 0);
    checkOutput("staleHoldData", bus.data_out, 0);
    checkOutput("staleHoldBusy", busy, 1);
    ackManual  = 1'b0;
    respEnable = 1'b1;
    applyStimulus(3'd2, 50, acc);
    checkOutput("postResetPush", acc, 1);
    waitIdle(300, "idleAfterReset");
    checkOutput("postResetDrained", expQ.size(), 0);
    checkOutput("txCountPostReset", txCount, completions % 4);

    // Random traffic against the responding pipeline model
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) waitNeg();
      applyStimulus(DW'($urandom_range(0, 7)), 300, acc);
      checkOutput("randomPushAccepted", acc, 1);
    end
    waitIdle(3000, "idleAfterRandom");
    checkOutput("randomDrained", expQ.size(), 0);
    checkOutput("txCountRandom", txCount, completions % 4);
    checkOutput("finalInReady", bus.in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
